alu_div_seq: RTL and testbench
==============================

Name: alu_div_seq

Overview:
- Multicycle unsigned 32-bit restoring divider that produces its results by sequencing the shared ALU, one quotient bit per iteration.
- Sits beside the multicycle datapath and arbitrates the single ALU instance.
  - When idle, the datapath's ALU request passes straight through.
  - While dividing, the sequencer owns the ALU and stalls the datapath.
- Uses only two ALU operations:
  - Op 7: carry-out of A+B+1, i.e. no-borrow of A−B when B is the inverted divisor.
  - Op 6: A+B+1, i.e. A−B when B is the inverted divisor.

Parameters:
- WIDTH, 32, data width; must equal the ALU width.
- CNT_W, 5, iteration counter width; log2(WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a division; accepted only when start_ready=1.
- start_ready  out  1  high in IDLE only.
- dividend  in  WIDTH  sampled on an accepted start.
- divisor  in  WIDTH  sampled on an accepted start.
- done_valid  out  1  result valid; held high until done_ready.
- done_ready  in  1  consumer accepts the result.
- quotient  out  WIDTH  registered result.
- remainder  out  WIDTH  registered result.
- div_by_zero  out  1  registered; qualified by done_valid.
- dp_alu_op  in  3  datapath ALU operation request.
- dp_alu_a  in  WIDTH  datapath ALU operand A.
- dp_alu_b  in  WIDTH  datapath ALU operand B.
- dp_stall  out  1  high whenever state≠IDLE.
- alu_op  out  3  to shared ALU ALU_operation.
- alu_a  out  WIDTH  to shared ALU A.
- alu_b  out  WIDTH  to shared ALU B.
- alu_res  in  WIDTH  from shared ALU res.

Behaviour:
- Registers:
  - state ∈ {IDLE, CMP, SUB, DONE}
  - rem, quo, dvs (WIDTH each)
  - cnt (CNT_W)
  - dbz
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - rem, quo, dvs, cnt, dbz all 0.
  - Therefore done_valid=0, quotient=0, remainder=0, div_by_zero=0, dp_stall=0.
  - Reset mid-operation aborts the division; no result is produced.
- Outputs: quotient=quo, remainder=rem, div_by_zero=dbz, done_valid=(state==DONE).
- ALU mux (combinational):
  - IDLE and DONE: alu_op/a/b = dp_alu_*.
  - CMP: op=7, a=rs, b=~dvs.
  - SUB: op=6, a=rem, b=~dvs.
- Definitions:
  - rs = {rem[WIDTH-2:0], quo[WIDTH-1]}, the shifted partial remainder.
  - ge = alu_res[0] | rem[WIDTH-1]. A shifted-out MSB of 1 forces ge=1, and the 32-bit subtract result is then exact modulo 2^WIDTH.
- IDLE, start=1:
  - Load quo←dividend, dvs←divisor, rem←0, cnt←0.
  - If divisor==0: quo←all ones, rem←dividend, dbz←1, go to DONE.
  - Otherwise dbz←0, go to CMP.
- CMP:
  - rem←rs in all cases.
  - If ge: quo←{quo[WIDTH-2:0],1}, go to SUB. cnt is unchanged.
  - If !ge: quo←{quo[WIDTH-2:0],0}, cnt←cnt+1. Go to DONE if cnt==WIDTH-1, else stay in CMP.
- SUB:
  - rem←alu_res, cnt←cnt+1.
  - Go to DONE if cnt==WIDTH-1, else go to CMP.
- DONE:
  - Results are held stable.
  - When done_ready=1, go to IDLE. start is not accepted in that same cycle.
- Latency:
  - After the accepting edge, the sequencer spends exactly WIDTH+popcount(quotient) cycles in CMP/SUB.
  - done_valid is high from the next cycle.
  - Divide-by-zero: done_valid is high the cycle after acceptance.
- dp_stall is high from the cycle after acceptance through the DONE cycle in which done_ready is sampled.
- Boundary rules:
  - start while not IDLE is ignored.
  - dividend/divisor changes after acceptance have no effect.
  - done_ready while not in DONE is ignored.
  - cnt never wraps: the exit test at WIDTH-1 precedes the increment.

Test Plan:
- 100/7, done_ready=1 → quotient=14, remainder=2, div_by_zero=0; 35 busy cycles; alu_op sequence contains exactly 3 op-6 cycles.
- 0xFFFFFFFF/1 → quotient=0xFFFFFFFF, remainder=0; 64 busy cycles. Then 5/9 → quotient=0, remainder=5; 32 busy cycles, never enters SUB.
- 0xFFFFFFFF/0x80000001 (MSB-forced ge path) → quotient=1, remainder=0x7FFFFFFE.
- 1234/0 → done_valid one cycle after acceptance; quotient=0xFFFFFFFF, remainder=1234, div_by_zero=1.
- done_ready held low 10 cycles in DONE → outputs and dp_stall stable; start pulses ignored; IDLE only after done_ready=1.
- IDLE with dp_alu_op=2, a=3, b=4 → alu_op=2, alu_a=3, alu_b=4 same cycle.
- Assert rst_n low mid-CMP → immediate IDLE, all outputs 0, no done_valid.

Source files
------------

// File: rtl/alu_div_seq_if.sv
// Start/done handshake bundle for the ALU-sequenced divider.
// master = requester, slave = divider.
interface alu_div_seq_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic             start_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             done_valid;
  logic             done_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor, done_ready,
    input  start_ready, done_valid,
    input  quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor, done_ready,
    output start_ready, done_valid,
    output quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/alu_div_seq.sv
// Restoring unsigned divider, one quotient bit per pass,
// borrowing the shared ALU and stalling the datapath meanwhile.
module alu_div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_div_seq_if.slave     bus,
  input  logic [2:0]       dp_alu_op,
  input  logic [WIDTH-1:0] dp_alu_a,
  input  logic [WIDTH-1:0] dp_alu_b,
  output logic             dp_stall,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_res
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_SUB  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_GE  = 3'd7;
  localparam logic [2:0] OP_SUB = 3'd6;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] rs;
  logic             ge;
  logic             last;
  logic             st_cmp;
  logic             st_sub;

  assign rs     = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
  // A 1 shifted out of rem means the true value exceeds any divisor.
  assign ge     = alu_res[0] | rem_q[WIDTH-1];
  assign last   = (cnt_q == CNT_W'(WIDTH-1));
  assign st_cmp = (state_q == S_CMP);
  assign st_sub = (state_q == S_SUB);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          quo_d = bus.dividend;
          dvs_d = bus.divisor;
          rem_d = '0;
          cnt_d = '0;
          if (bus.divisor == '0) begin
            quo_d   = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            dbz_d   = 1'b0;
            state_d = S_CMP;
          end
        end
      end
      S_CMP: begin
        rem_d = rs;
        quo_d = {quo_q[WIDTH-2:0], ge};
        if (ge) begin
          state_d = S_SUB;
        end else if (last) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SUB: begin
        rem_d = alu_res;
        if (last) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_CMP;
        end
      end
      S_DONE: begin
        if (bus.done_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    alu_op = dp_alu_op;
    alu_a  = dp_alu_a;
    alu_b  = dp_alu_b;
    unique case (1'b1)
      st_cmp: begin
        alu_op = OP_GE;
        alu_a  = rs;
        alu_b  = ~dvs_q;
      end
      st_sub: begin
        alu_op = OP_SUB;
        alu_a  = rem_q;
        alu_b  = ~dvs_q;
      end
      default: begin
        alu_op = dp_alu_op;
      end
    endcase
  end

  assign bus.start_ready = (state_q == S_IDLE);
  assign bus.done_valid  = (state_q == S_DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign dp_stall        = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_div_seq.sv
// Randomized bench for alu_div_seq against a plain-arithmetic
// division model, with a behavioural shared ALU.
module tb_alu_div_seq;

  logic        clk;
  logic        rst_n;
  logic [2:0]  dp_alu_op;
  logic [31:0] dp_alu_a;
  logic [31:0] dp_alu_b;
  logic        dp_stall;
  logic [2:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_res;

  int vectors;
  int miscompares;

  alu_div_seq_if #(.WIDTH(32)) bus ();

  alu_div_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dp_alu_op (dp_alu_op),
    .dp_alu_a  (dp_alu_a),
    .dp_alu_b  (dp_alu_b),
    .dp_stall  (dp_stall),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_res   (alu_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: op7 = carry of A+B+1, op6 = A+B+1, others arbitrary.
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + 33'd1;
    case (alu_op)
      3'd7:    alu_res = {31'd0, alu_sum[32]};
      3'd6:    alu_res = alu_sum[31:0];
      3'd2:    alu_res = alu_a + alu_b;
      default: alu_res = alu_a ^ alu_b;
    endcase
  end

  function automatic void ref_div(
    input  logic [31:0] a, b,
    output logic [31:0] q, r,
    output logic z,
    output int busy, n6
  );
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1; busy = 0; n6 = 0;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
      n6 = $countones(q);
      busy = 32 + n6;
    end
  endfunction

  // Called at a negedge in IDLE; returns at the negedge done_valid is seen.
  task automatic run_div(
    input  logic [31:0] a, b,
    output logic [31:0] q, r,
    output logic z,
    output int busy, n6,
    output bit to
  );
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    bus.done_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.dividend = $urandom; bus.divisor = $urandom;
    busy = 0; n6 = 0;
    while (!bus.done_valid && busy < 200) begin
      if (alu_op == 3'd6) n6++;
      busy++;
      bus.start = 1'($urandom);
      bus.done_ready = 1'($urandom);
      dp_alu_op = 3'($urandom); dp_alu_a = $urandom; dp_alu_b = $urandom;
      @(negedge clk);
    end
    bus.start = 1'b0; bus.done_ready = 1'b0;
    to = !bus.done_valid;
    q = bus.quotient; r = bus.remainder; z = bus.div_by_zero;
  endtask

  task automatic release_done();
    bus.done_ready = 1'b1;
    @(negedge clk);
    bus.done_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.done_ready = 1'b0;
    bus.dividend = '0; bus.divisor = '0;
    dp_alu_op = '0; dp_alu_a = '0; dp_alu_b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.done_valid, bus.div_by_zero, dp_stall, bus.start_ready} !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_flags got dv/dbz/stall/rdy=%b want 0001",
               {bus.done_valid, bus.div_by_zero, dp_stall, bus.start_ready});
    end
    vectors++;
    if ({bus.quotient, bus.remainder} !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_data got q=%h r=%h want 0/0", bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_passthru();
    dp_alu_op = 3'd2; dp_alu_a = 32'd3; dp_alu_b = 32'd4;
    #1;
    vectors++;
    if ({alu_op, alu_a, alu_b} !== {3'd2, 32'd3, 32'd4}) begin
      miscompares++;
      $display("FAIL passthru got op=%0d a=%0d b=%0d want 2/3/4", alu_op, alu_a, alu_b);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [4] = '{32'd100, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF};
    logic [31:0] tb [4] = '{32'd7, 32'd1, 32'd9, 32'h8000_0001};
    logic [31:0] q, r, eq, er;
    logic z, ez;
    int busy, n6, eb, e6;
    bit to;
    for (int i = 0; i < 4; i++) begin
      ref_div(ta[i], tb[i], eq, er, ez, eb, e6);
      run_div(ta[i], tb[i], q, r, z, busy, n6, to);
      vectors++;
      if (to) begin
        miscompares++;
        $display("FAIL dir%0d_timeout got no done_valid want done", i);
      end
      vectors++;
      if ({q, r, z} !== {eq, er, ez}) begin
        miscompares++;
        $display("FAIL dir%0d_result got q=%h r=%h z=%b want q=%h r=%h z=%b",
                 i, q, r, z, eq, er, ez);
      end
      vectors++;
      if (busy !== eb || n6 !== e6) begin
        miscompares++;
        $display("FAIL dir%0d_timing got busy=%0d sub=%0d want busy=%0d sub=%0d",
                 i, busy, n6, eb, e6);
      end
      release_done();
    end
  endtask

  task automatic test_dbz();
    logic [31:0] q, r;
    logic z;
    int busy, n6;
    bit to;
    run_div(32'd1234, 32'd0, q, r, z, busy, n6, to);
    vectors++;
    if (to || busy !== 0) begin
      miscompares++;
      $display("FAIL dbz_latency got busy=%0d to=%b want busy=0", busy, to);
    end
    vectors++;
    if ({q, r, z} !== {32'hFFFF_FFFF, 32'd1234, 1'b1}) begin
      miscompares++;
      $display("FAIL dbz_result got q=%h r=%0d z=%b want ffffffff/1234/1", q, r, z);
    end
    release_done();
  endtask

  task automatic test_hold();
    logic [31:0] q, r;
    logic z;
    int busy, n6, bad;
    bit to;
    run_div(32'd100, 32'd7, q, r, z, busy, n6, to);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      bus.start = 1'(i % 2);
      bus.dividend = $urandom; bus.divisor = $urandom;
      dp_alu_op = 3'($urandom); dp_alu_a = $urandom; dp_alu_b = $urandom;
      @(negedge clk);
      if ({bus.done_valid, dp_stall, bus.start_ready} !== 3'b110) bad++;
      if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {32'd14, 32'd2, 1'b0}) bad++;
      if ({alu_op, alu_a, alu_b} !== {dp_alu_op, dp_alu_a, dp_alu_b}) bad++;
    end
    bus.start = 1'b0;
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL hold_stable got %0d bad samples want 0", bad);
    end
    release_done();
    vectors++;
    if ({bus.done_valid, dp_stall, bus.start_ready} !== 3'b001 || bus.quotient !== 32'd14) begin
      miscompares++;
      $display("FAIL hold_release got dv/stall/rdy=%b q=%0d want 001 q=14",
               {bus.done_valid, dp_stall, bus.start_ready}, bus.quotient);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r, eq, er;
    logic z, ez;
    int busy, n6, eb, e6;
    bit to;
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      ref_div(a, b, eq, er, ez, eb, e6);
      run_div(a, b, q, r, z, busy, n6, to);
      vectors++;
      if (to || {q, r, z} !== {eq, er, ez} || busy !== eb || n6 !== e6) begin
        miscompares++;
        $display("FAIL rand%0d %h/%h got q=%h r=%h z=%b busy=%0d sub=%0d want q=%h r=%h z=%b busy=%0d sub=%0d",
                 i, a, b, q, r, z, busy, n6, eq, er, ez, eb, e6);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_done();
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    bus.start = 1'b1; bus.dividend = 32'hFFFF_FFFF; bus.divisor = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.done_valid, dp_stall, bus.start_ready, bus.div_by_zero} !== 4'b0010 ||
        {bus.quotient, bus.remainder} !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_mid got dv/stall/rdy/dbz=%b q=%h r=%h want 0010 0 0",
               {bus.done_valid, dp_stall, bus.start_ready, bus.div_by_zero},
               bus.quotient, bus.remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (bus.done_valid || dp_stall) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL reset_abort got activity after reset want none");
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_passthru();
    test_directed();
    test_dbz();
    test_hold();
    test_random();
    test_reset_mid();
    test_directed();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
